// File: rtl/multi_dataflow_job_sequencer.sv
// -----------------------------------------------------------------------------
// multi_dataflow_job_sequencer
//
// Purpose:
//   Sequences jobs through a reconfigurable dataflow datapath. A job is a
//   descriptor {configuration ID, number of input tokens, number of output
//   tokens}. When a job is accepted, the sequencer may switch the datapath
//   configuration, which takes RECONF_CYCLES cycles with the input stream
//   gated. It then admits exactly nin input tokens into the datapath and
//   watches the datapath output handshake until nout tokens have left. It
//   then pulses done_o for one cycle and returns to idle.
//
// Parameters:
//   CNT_W          width of the per-job token counters
//   CFG_W          width of the datapath configuration ID
//   RECONF_CYCLES  stream-gated cycles after a configuration change (1..255)
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   clear_i                  synchronous soft clear, highest priority
//   job_valid_i/job_ready_o  job descriptor handshake
//   job_cfg_i, job_nin_i,    job descriptor fields
//   job_nout_i
//   in_valid_i/in_ready_o    upstream input stream handshake
//   dp_in_valid_o/           datapath input stream handshake
//   dp_in_ready_i
//   dp_out_valid_i/          datapath output handshake (observed only)
//   dp_out_ready_i
//   cfg_id_o                 active datapath configuration ID
//   busy_o, idle_o, done_o   status flags
//   in_cnt_o, out_cnt_o      tokens admitted / produced for the current job
// -----------------------------------------------------------------------------
module multi_dataflow_job_sequencer #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned CFG_W         = 8,
  parameter int unsigned RECONF_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  // job descriptor handshake
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [CFG_W-1:0] job_cfg_i,
  input  logic [CNT_W-1:0] job_nin_i,
  input  logic [CNT_W-1:0] job_nout_i,
  // upstream input stream
  input  logic             in_valid_i,
  output logic             in_ready_o,
  // datapath input stream
  output logic             dp_in_valid_o,
  input  logic             dp_in_ready_i,
  // datapath output handshake, observed only
  input  logic             dp_out_valid_i,
  input  logic             dp_out_ready_i,
  // configuration and status
  output logic [CFG_W-1:0] cfg_id_o,
  output logic             busy_o,
  output logic             idle_o,
  output logic             done_o,
  output logic [CNT_W-1:0] in_cnt_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  // Reconfiguration countdown width; RECONF_CYCLES is limited to 255.
  localparam int unsigned RC_W = 8;
  // The countdown is loaded with RECONF_CYCLES-1 and RECONF is left when it
  // reads zero, which gives exactly RECONF_CYCLES cycles in RECONF.
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECONF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECONF = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] nin_q, nin_d;
  logic [CNT_W-1:0] nout_q, nout_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [RC_W-1:0]  rc_q, rc_d;

  logic is_idle;
  logic is_run;
  logic job_hs;
  logic gate;
  logic in_hs;
  logic out_hs;
  logic out_last;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign is_idle = (state_q == ST_IDLE);
  assign is_run  = (state_q == ST_RUN);

  assign job_ready_o = is_idle;
  assign job_hs      = job_valid_i & job_ready_o;

  // The input gate stops admitting tokens once nin have entered the datapath,
  // so in_cnt can never overshoot nin.
  assign gate = is_run & (in_cnt_q < nin_q);

  assign dp_in_valid_o = in_valid_i & gate;
  assign in_ready_o    = dp_in_ready_i & gate;
  assign in_hs         = dp_in_valid_o & dp_in_ready_i;

  // Output tokens are only counted in RUN; the bound on nout is redundant
  // while RUN is left on the last token, but keeps out_cnt safe regardless.
  assign out_hs   = is_run & dp_out_valid_i & dp_out_ready_i & (out_cnt_q < nout_q);
  assign out_last = (out_cnt_q == (nout_q - CNT_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    nin_d     = nin_q;
    nout_d    = nout_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    rc_d      = rc_q;

    if (clear_i) begin
      // Soft clear wins over everything, including a job handshake that
      // happens in the same cycle: that job is simply dropped.
      state_d   = ST_IDLE;
      cfg_d     = '0;
      nin_d     = '0;
      nout_d    = '0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      rc_d      = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (job_hs) begin
            nin_d     = job_nin_i;
            nout_d    = job_nout_i;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            if (job_nout_i == '0) begin
              // Nothing to wait for: finish immediately and leave the
              // datapath configuration alone.
              state_d = ST_DONE;
            end else if (job_cfg_i != cfg_q) begin
              cfg_d   = job_cfg_i;
              rc_d    = RC_LAST;
              state_d = ST_RECONF;
            end else begin
              state_d = ST_RUN;
            end
          end
        end

        ST_RECONF: begin
          if (rc_q == '0) begin
            state_d = ST_RUN;
          end else begin
            rc_d = rc_q - RC_W'(1);
          end
        end

        ST_RUN: begin
          // Input and output handshakes are independent and may both be
          // counted in the same cycle.
          if (in_hs) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
          if (out_hs) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
            // Completion is decided by the output side alone; input tokens
            // still outstanding at that point are not waited for.
            if (out_last) begin
              state_d = ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // One-cycle completion pulse; counters keep their final values
          // until the next job is accepted.
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      nin_q     <= '0;
      nout_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      nin_q     <= nin_d;
      nout_q    <= nout_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      rc_q      <= rc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, all decoded from registered state
  // ---------------------------------------------------------------------------
  assign cfg_id_o  = cfg_q;
  assign busy_o    = (state_q == ST_RECONF) | is_run;
  assign idle_o    = is_idle;
  assign done_o    = (state_q == ST_DONE);
  assign in_cnt_o  = in_cnt_q;
  assign out_cnt_o = out_cnt_q;

endmodule

// File: tb/tb_multi_dataflow_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multi_dataflow_job_sequencer
//
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences (completion, input limiting, soft clear, async reset) and a
// randomized phase checked against a job-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_multi_dataflow_job_sequencer;

  localparam int CNT_W = 16;
  localparam int CFG_W = 8;
  localparam int RC    = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic             job_valid_i = 1'b0;
  logic             job_ready_o;
  logic [CFG_W-1:0] job_cfg_i = '0;
  logic [CNT_W-1:0] job_nin_i = '0;
  logic [CNT_W-1:0] job_nout_i = '0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic             dp_in_valid_o;
  logic             dp_in_ready_i = 1'b0;
  logic             dp_out_valid_i = 1'b0;
  logic             dp_out_ready_i = 1'b0;
  logic [CFG_W-1:0] cfg_id_o;
  logic             busy_o;
  logic             idle_o;
  logic             done_o;
  logic [CNT_W-1:0] in_cnt_o;
  logic [CNT_W-1:0] out_cnt_o;

  always #5 clk_i = ~clk_i;

  multi_dataflow_job_sequencer #(
    .CNT_W         (CNT_W),
    .CFG_W         (CFG_W),
    .RECONF_CYCLES (RC)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_cfg_i      (job_cfg_i),
    .job_nin_i      (job_nin_i),
    .job_nout_i     (job_nout_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .dp_in_valid_o  (dp_in_valid_o),
    .dp_in_ready_i  (dp_in_ready_i),
    .dp_out_valid_i (dp_out_valid_i),
    .dp_out_ready_i (dp_out_ready_i),
    .cfg_id_o       (cfg_id_o),
    .busy_o         (busy_o),
    .idle_o         (idle_o),
    .done_o         (done_o),
    .in_cnt_o       (in_cnt_o),
    .out_cnt_o      (out_cnt_o)
  );

  typedef struct {
    logic       job_valid;
    logic [7:0] cfg;
    logic [15:0] nin;
    logic [15:0] nout;
    logic       in_valid;
    logic       dp_in_ready;
    logic       dp_out_valid;
    logic       dp_out_ready;
    logic       clear;
  } stim_t;

  typedef struct {
    logic        job_ready;
    logic        busy;
    logic        idle;
    logic        done;
    logic        dp_in_valid;
    logic        in_ready;
    logic [7:0]  cfg_id;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t r;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  // ---------------------------------------------------------------------------
  // Job-level reference model
  // ---------------------------------------------------------------------------
  logic [7:0]  m_cfg;
  logic [15:0] m_nin, m_nout, m_in, m_out;
  bit          m_job;          // a job with outputs pending is in progress
  bit          m_done;         // this is the completion cycle
  int          m_reconf_left;  // gated cycles still to wait before streaming

  task automatic model_reset();
    m_cfg = '0; m_nin = '0; m_nout = '0; m_in = '0; m_out = '0;
    m_job = 1'b0; m_done = 1'b0; m_reconf_left = 0;
  endtask

  function automatic resp_t model_resp();
    resp_t r;
    bit streaming, open;
    streaming     = m_job && (m_reconf_left == 0);
    open          = streaming && (m_in < m_nin);
    r.job_ready   = !m_job && !m_done;
    r.idle        = !m_job && !m_done;
    r.busy        = m_job;
    r.done        = m_done;
    r.dp_in_valid = in_valid_i & open;
    r.in_ready    = dp_in_ready_i & open;
    r.cfg_id      = m_cfg;
    r.in_cnt      = m_in;
    r.out_cnt     = m_out;
    return r;
  endfunction

  task automatic model_step();
    if (clear_i) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_job) begin
      if (job_valid_i) begin
        m_nin = job_nin_i; m_nout = job_nout_i; m_in = '0; m_out = '0;
        if (job_nout_i == 0) begin
          m_done = 1'b1;
        end else begin
          m_job = 1'b1;
          if (job_cfg_i != m_cfg) begin
            m_cfg = job_cfg_i;
            m_reconf_left = RC;
          end else begin
            m_reconf_left = 0;
          end
        end
      end
    end else if (m_reconf_left > 0) begin
      m_reconf_left = m_reconf_left - 1;
    end else begin
      if (in_valid_i && dp_in_ready_i && (m_in < m_nin)) m_in = m_in + 16'd1;
      if (dp_out_valid_i && dp_out_ready_i && (m_out < m_nout)) begin
        m_out = m_out + 16'd1;
        if (m_out == m_nout) begin
          m_job  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_resp(input string name, input resp_t e);
    chk({name, ".job_ready"},   32'(job_ready_o),   32'(e.job_ready));
    chk({name, ".busy"},        32'(busy_o),        32'(e.busy));
    chk({name, ".idle"},        32'(idle_o),        32'(e.idle));
    chk({name, ".done"},        32'(done_o),        32'(e.done));
    chk({name, ".dp_in_valid"}, 32'(dp_in_valid_o), 32'(e.dp_in_valid));
    chk({name, ".in_ready"},    32'(in_ready_o),    32'(e.in_ready));
    chk({name, ".cfg_id"},      32'(cfg_id_o),      32'(e.cfg_id));
    chk({name, ".in_cnt"},      32'(in_cnt_o),      32'(e.in_cnt));
    chk({name, ".out_cnt"},     32'(out_cnt_o),     32'(e.out_cnt));
  endtask

  task automatic drive(input stim_t s);
    job_valid_i    = s.job_valid;
    job_cfg_i      = s.cfg;
    job_nin_i      = s.nin;
    job_nout_i     = s.nout;
    in_valid_i     = s.in_valid;
    dp_in_ready_i  = s.dp_in_ready;
    dp_out_valid_i = s.dp_out_valid;
    dp_out_ready_i = s.dp_out_ready;
    clear_i        = s.clear;
  endtask

  task automatic drive_quiet();
    stim_t s;
    s = '{1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(s);
  endtask

  task automatic set_job(input int cfg, input int nin, input int nout);
    job_valid_i = 1'b1;
    job_cfg_i   = CFG_W'(cfg);
    job_nin_i   = CNT_W'(nin);
    job_nout_i  = CNT_W'(nout);
  endtask

  // Falling-edge sample checked against the model.
  task automatic sample(input string name);
    @(negedge clk_i);
    check_resp(name, model_resp());
  endtask

  // Rising edge: the model advances with the inputs the DUT just saw.
  task automatic advance();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  function automatic vec_t mk(bit jv, int cfg, int nin, int nout, bit iv, bit dr,
                              bit ov, bit orr, bit clr, bit jr, bit bs, bit id,
                              bit dn, bit dv, bit ir, int cid, int ic, int oc);
    vec_t v;
    v.s = '{jv, 8'(cfg), 16'(nin), 16'(nout), iv, dr, ov, orr, clr};
    v.r = '{jr, bs, id, dn, dv, ir, 8'(cid), 16'(ic), 16'(oc)};
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t  tbl[14];
    resp_t rst_exp;
    int    dones, hs;
    bit    seen_done, seen_idle;

    rst_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0};

    //            jv cfg nin nout iv dr ov or clr | jr bs id dn dv ir cid ic oc
    tbl[0]  = mk(1, 5, 2, 1,   1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,   1, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 5, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,   1, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 5, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,   1, 1, 0, 0, 0,   0, 1, 0, 0, 1, 1, 5, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,   1, 1, 0, 0, 0,   0, 1, 0, 0, 1, 1, 5, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0,   1, 1, 1, 1, 0,   0, 1, 0, 0, 0, 0, 5, 2, 0);
    tbl[6]  = mk(1, 5, 0, 0,   0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 5, 2, 1);
    tbl[7]  = mk(1, 9, 3, 0,   0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 5, 2, 1);
    tbl[8]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 5, 0, 0);
    tbl[9]  = mk(1, 5, 1, 1,   0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 5, 0, 0);
    tbl[10] = mk(1, 0, 1, 1,   0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,   1, 0, 1, 1, 0,   0, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0, 1);

    // Reset state while reset is held.
    model_reset();
    drive_quiet();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_resp("reset_hold", rst_exp);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed vector table: reconfiguration, input limit, DONE refusal,
    // nout==0 job, clear dropping a job, same-cfg job ending on outputs.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].s);
      @(negedge clk_i);
      check_resp($sformatf("vec%0d", i), tbl[i].r);
      advance();
    end
    $display("table phase: %0d checks, %0d passed", n_total, n_pass);

    // Same-cfg job: RUN immediately, 4 inputs, one output every 3 cycles.
    drive_quiet();
    set_job(0, 4, 2);
    in_valid_i = 1'b1; dp_in_ready_i = 1'b1; dp_out_ready_i = 1'b1;
    sample("seq_a_accept");
    advance();
    job_valid_i = 1'b0;
    dones = 0; seen_done = 0; seen_idle = 0;
    for (int c = 0; c < 30 && !seen_idle; c++) begin
      dp_out_valid_i = ((c % 3) == 2);
      sample("seq_a_run");
      if (c == 0) chk("seq_a_run_next", 32'(dp_in_valid_o), 32'd1);
      if (seen_done) begin
        chk("seq_a_idle_after", 32'(idle_o), 32'd1);
        seen_idle = 1;
      end
      if (done_o) begin
        dones++;
        seen_done = 1;
        chk("seq_a_in_cnt", 32'(in_cnt_o), 32'd4);
        chk("seq_a_out_cnt", 32'(out_cnt_o), 32'd2);
      end
      advance();
    end
    chk("seq_a_done_pulses", 32'(dones), 32'd1);
    chk("seq_a_finished", 32'(seen_idle), 32'd1);
    $display("seq_a: done pulses %0d", dones);

    // nin=3 with the input always valid and no outputs yet.
    drive_quiet();
    set_job(0, 3, 2);
    in_valid_i = 1'b1; dp_in_ready_i = 1'b1; dp_out_ready_i = 1'b1;
    sample("seq_b_accept");
    advance();
    job_valid_i = 1'b0;
    hs = 0;
    for (int c = 0; c < 8; c++) begin
      sample("seq_b_in");
      if (dp_in_valid_o && dp_in_ready_i) hs++;
      advance();
    end
    @(negedge clk_i);
    chk("seq_b_handshakes", 32'(hs), 32'd3);
    chk("seq_b_in_ready_closed", 32'(in_ready_o), 32'd0);
    chk("seq_b_busy_waiting", 32'(busy_o), 32'd1);
    advance();
    dp_out_valid_i = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 10 && !seen_done; c++) begin
      sample("seq_b_out");
      if (done_o) seen_done = 1;
      advance();
    end
    chk("seq_b_done_seen", 32'(seen_done), 32'd1);
    $display("seq_b: dp handshakes %0d", hs);

    // Soft clear in RUN after two inputs, then a back-to-back job.
    drive_quiet();
    sample("seq_c_idle");
    advance();
    set_job(0, 5, 3);
    in_valid_i = 1'b1; dp_in_ready_i = 1'b1;
    sample("seq_c_accept");
    advance();
    job_valid_i = 1'b0;
    sample("seq_c_run0");
    advance();
    sample("seq_c_run1");
    advance();
    clear_i = 1'b1;
    sample("seq_c_clear");
    chk("seq_c_in_cnt_before", 32'(in_cnt_o), 32'd2);
    advance();
    clear_i = 1'b0;
    set_job(3, 1, 1);
    dp_out_valid_i = 1'b1; dp_out_ready_i = 1'b1;
    sample("seq_c_after_clear");
    chk("seq_c_idle", 32'(idle_o), 32'd1);
    chk("seq_c_cnt0", 32'(in_cnt_o), 32'd0);
    chk("seq_c_cfg0", 32'(cfg_id_o), 32'd0);
    chk("seq_c_no_done", 32'(done_o), 32'd0);
    advance();
    job_valid_i = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 10 && !seen_done; c++) begin
      sample("seq_c_job2");
      if (done_o) seen_done = 1;
      advance();
    end
    chk("seq_c_job2_done", 32'(seen_done), 32'd1);
    chk("seq_c_job2_cfg", 32'(cfg_id_o), 32'd3);
    $display("seq_c: clear then job2 done=%0d", seen_done);

    // Async reset during RECONF, then a job runs to completion.
    drive_quiet();
    sample("seq_d_idle");
    advance();
    set_job(7, 2, 1);
    sample("seq_d_accept");
    advance();
    drive_quiet();
    sample("seq_d_reconf");
    chk("seq_d_in_reconf", 32'(busy_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_resp("seq_d_async_rst", rst_exp);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    check_resp("seq_d_rst_held", rst_exp);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    set_job(7, 2, 1);
    in_valid_i = 1'b1; dp_in_ready_i = 1'b1;
    sample("seq_d_accept2");
    advance();
    job_valid_i = 1'b0;
    dp_out_ready_i = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 12 && !seen_done; c++) begin
      dp_out_valid_i = (c >= 4);
      sample("seq_d_job");
      if (done_o) seen_done = 1;
      advance();
    end
    chk("seq_d_job_done", 32'(seen_done), 32'd1);
    $display("seq_d: async reset then job done=%0d", seen_done);

    // Randomized phase against the reference model.
    for (int c = 0; c < 3000; c++) begin
      job_valid_i    = ($urandom_range(0, 3) == 0);
      job_cfg_i      = CFG_W'($urandom_range(0, 3));
      job_nin_i      = CNT_W'($urandom_range(0, 6));
      job_nout_i     = CNT_W'($urandom_range(0, 4));
      in_valid_i     = ($urandom_range(0, 3) != 0);
      dp_in_ready_i  = ($urandom_range(0, 3) != 0);
      dp_out_valid_i = ($urandom_range(0, 2) == 0);
      dp_out_ready_i = ($urandom_range(0, 3) != 0);
      clear_i        = ($urandom_range(0, 99) == 0);
      sample($sformatf("rand%0d", c));
      advance();
    end
    $display("random phase complete");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_dataflow_job_sequencer.md
MULTI_DATAFLOW_JOB_SEQUENCER -- requirements
Module: multi_dataflow_job_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning width of the per-job token counters.
REQ-002 The block SHALL have parameter CFG_W, default 8, meaning width of the datapath configuration ID.
REQ-003 The block SHALL have parameter RECONF_CYCLES, default 2, meaning the number of stream-gated cycles after a configuration ID change; legal range 1-255.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port clear_i, input, 1 bit: synchronous soft clear, active-high.
REQ-007 The block SHALL have ports job_valid_i (input, 1), job_ready_o (output, 1), job_cfg_i (input, CFG_W), job_nin_i (input, CNT_W) and job_nout_i (input, CNT_W): the job descriptor handshake.
REQ-008 The block SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): the upstream input-stream handshake.
REQ-009 The block SHALL have ports dp_in_valid_o (output, 1) and dp_in_ready_i (input, 1): the datapath input-stream handshake.
REQ-010 The block SHALL have ports dp_out_valid_i (input, 1) and dp_out_ready_i (input, 1): the datapath output handshake, observed only and never driven.
REQ-011 The block SHALL have port cfg_id_o, output, CFG_W bits: the active datapath configuration ID.
REQ-012 The block SHALL have ports busy_o (output, 1), idle_o (output, 1), done_o (output, 1), in_cnt_o (output, CNT_W) and out_cnt_o (output, CNT_W): status.

Function
REQ-013 The block SHALL implement the states IDLE, RECONF, RUN and DONE.
REQ-014 In IDLE, job_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-015 On job_valid_i & job_ready_o, the block SHALL latch job_cfg_i, job_nin_i and job_nout_i, and clear in_cnt_o and out_cnt_o.
REQ-016 When a job is accepted with job_nout_i==0, the next state SHALL be DONE and cfg_id_o SHALL be unchanged.
REQ-017 When a job is accepted with job_nout_i!=0 and job_cfg_i!=cfg_id_o, then on the accepting edge cfg_id_o SHALL take job_cfg_i and the next state SHALL be RECONF.
REQ-018 When a job is accepted with job_nout_i!=0 and job_cfg_i==cfg_id_o, the next state SHALL be RUN.
REQ-019 The block SHALL remain in RECONF for exactly RECONF_CYCLES cycles and then enter RUN.
REQ-020 The input gate SHALL be open only when the state is RUN and in_cnt_o < latched nin.
REQ-021 The block SHALL drive dp_in_valid_o = in_valid_i & gate and in_ready_o = dp_in_ready_i & gate, both purely combinational.
REQ-022 When the gate is closed, dp_in_valid_o and in_ready_o SHALL both be 0.
REQ-023 In RUN, in_cnt_o SHALL increment on dp_in_valid_o & dp_in_ready_i and SHALL never exceed nin.
REQ-024 In RUN, out_cnt_o SHALL increment on dp_out_valid_i & dp_out_ready_i.
REQ-025 Output handshakes outside RUN SHALL be ignored, and out_cnt_o SHALL never exceed nout.
REQ-026 When an output handshake in RUN brings out_cnt_o to nout, the next state SHALL be DONE, regardless of in_cnt_o.
REQ-027 An input handshake and an output handshake in the same cycle SHALL both be counted.
REQ-028 In DONE, done_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-029 A new job SHALL NOT be accepted in the DONE cycle.
REQ-030 Status outputs SHALL follow the state: busy_o=1 in RECONF and RUN; idle_o=1 in IDLE only.
REQ-031 in_cnt_o and out_cnt_o SHALL hold their final values after DONE until the next job is accepted.
REQ-032 clear_i SHALL take priority over every other event: next state IDLE, counters 0, cfg_id_o 0, done_o 0.
REQ-033 A clear_i asserted in the same cycle as a job handshake SHALL cause the job to be dropped.

Reset
REQ-034 While rst_ni is 0, the block SHALL hold: state IDLE, cfg_id_o=0, in_cnt_o=0, out_cnt_o=0, done_o=0, busy_o=0, idle_o=1, job_ready_o=1, dp_in_valid_o=0, in_ready_o=0.
REQ-035 Reset asserted mid-job SHALL abort the job immediately and asynchronously, with no done_o pulse.
REQ-036 Latched job fields SHALL reset to 0.

Verification
REQ-037 Job cfg=0, nin=4, nout=2 from reset; input always valid; datapath always ready; one output every 3 cycles -> RUN on the next cycle, no RECONF, in_cnt_o=4, one done_o pulse after the 2nd output, idle_o=1 the cycle after.
REQ-038 Job cfg=5, RECONF_CYCLES=2, in_valid_i=1 -> cfg_id_o=5 one cycle after accept, dp_in_valid_o=0 for 2 cycles, then passes data.
REQ-039 nin=3 with the input always valid -> exactly 3 dp handshakes, then in_ready_o=0 while the block waits for outputs.
REQ-040 Job with nout=0 -> done_o one cycle after accept, cfg_id_o unchanged, in_cnt_o=0.
REQ-041 clear_i in RUN with in_cnt_o=2 -> next cycle: IDLE, counters 0, cfg_id_o=0, no done_o; then a back-to-back job is accepted normally.
REQ-042 rst_ni pulsed low in RECONF -> outputs immediately at reset values; a job accepted after release runs to completion.
